// File: rtl/add32_arbiter.sv
// Two-requester round-robin front end for one shared WIDTH-bit adder.
// Each operation takes IDLE -> EXEC -> DONE, and all outputs are registered.
module add32_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             cin0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin1,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_out,
  input  logic             add_cout,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  // state | meaning
  // IDLE  | sample requests, grant one, issue its operands
  // EXEC  | adder settles; capture sum and flags
  // DONE  | one-cycle done pulse for the granted requester
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t r_state;
  logic   r_prio;
  logic   r_gnt;

  logic   w_pick1;
  logic   w_ovf;
  logic   w_zero;

  // Requester 1 wins if it is alone, or if both request and priority names it.
  assign w_pick1 = req1 & (~req0 | r_prio);
  assign w_ovf   = (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                   (add_out[WIDTH-1] != add_a[WIDTH-1]);
  assign w_zero  = (add_out == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_prio  <= 1'b0;
      r_gnt   <= 1'b0;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req0 | req1) begin
            r_gnt   <= w_pick1;
            r_prio  <= ~w_pick1;
            add_a   <= w_pick1 ? a1 : a0;
            add_b   <= w_pick1 ? b1 : b0;
            add_cin <= w_pick1 ? cin1 : cin0;
            busy    <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          result  <= add_out;
          carry   <= add_cout;
          ovf     <= w_ovf;
          zero    <= w_zero;
          done0   <= ~r_gnt;
          done1   <= r_gnt;
          r_state <= S_DONE;
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
